// File: rtl/shifter_seq_if.sv
// rtl/shifter_seq_if.sv - start/busy/done command and result bundle for shifter_seq
interface shifter_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   d_out;
  logic               busy;
  logic               done;

  modport master (
    output start, op, shamt, d_in,
    input  d_out, busy, done
  );

  modport slave (
    input  start, op, shamt, d_in,
    output d_out, busy, done
  );
endinterface

// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - one-bit-per-clock shifter with start/busy/done handshake
// ROL/ROR exist only when SHIFTER_SEQ_ROTATE_EN is defined; otherwise they decode as NOP.
module shifter_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  shifter_seq_if.slave bus
);
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
`ifdef SHIFTER_SEQ_ROTATE_EN
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [2:0]         op_q, op_nxt;
  logic [WIDTH-1:0]   d_q, d_nxt;

  function automatic logic is_shift(input logic [2:0] o);
    logic r;
    r = 1'b0;
    case (o)
      OP_LSL, OP_LSR, OP_ASR: r = 1'b1;
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL, OP_ROR:         r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [2:0] o, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d;
    case (o)
      OP_LSL: r = {d[WIDTH-2:0], 1'b0};
      OP_LSR: r = {1'b0, d[WIDTH-1:1]};
      OP_ASR: r = {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef SHIFTER_SEQ_ROTATE_EN
      OP_ROL: r = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR: r = {d[0], d[WIDTH-1:1]};
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      d_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      d_q   <= d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    d_nxt     = d_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          op_nxt  = bus.op;
          cnt_nxt = bus.shamt;
          if (bus.op == OP_LOAD) begin
            d_nxt     = bus.d_in;
            state_nxt = S_DONE;
          end else if (is_shift(bus.op) && (bus.shamt != '0)) begin
            state_nxt = S_SHIFT;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The edge that applies the last step (counter at 1) also enters DONE.
        d_nxt   = step(op_q, d_q);
        cnt_nxt = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.d_out = d_q;
  assign bus.busy  = (state == S_SHIFT);
  assign bus.done  = (state == S_DONE);
endmodule
